// File: rtl/pico_mem_arbiter.sv
// pico_mem_arbiter
//   Two-requester arbiter in front of a single PicoRV32-native memory port
//   (the port that feeds the FreeAHB adapter). Requester 0 is the picorv32
//   core; requester 1 is a secondary native-IF master (boot loader / debug DMA).
//   One transaction is outstanding at a time. Downstream request outputs are
//   registered, and the completion goes back only to the granted requester.
//
// Parameters
//   RR_EN          1 = round-robin between m0/m1, 0 = fixed priority (m0 wins)
//   TIMEOUT_CYCLES BUSY cycles before abort (2..65535), timeout build only
//   ERR_RDATA      read data returned on an aborted transaction
//
// Optional build macro
//   PICO_MEM_ARB_TIMEOUT_EN  enables the BUSY watchdog; when undefined the
//                            arbiter waits indefinitely and timeout_err is 0.
//
// Ports
//   HCLK, HRESET          clock (rising edge), async active-high reset
//   mN_valid/instr/addr/wdata/wstrb   request from requester N
//   mN_ready/rdata        one-cycle completion pulse and read data to N
//   s_valid/instr/addr/wdata/wstrb    registered downstream request
//   s_ready/s_rdata       downstream completion and read data
//   grant                 owning requester, valid while busy=1
//   busy                  transaction in flight (state != IDLE)
//   timeout_err           sticky abort flag, cleared only by reset
module pico_mem_arbiter #(
   parameter int unsigned RR_EN          = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic        s_instr,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic        grant,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nx;
   logic        last_grant, last_grant_nx;
   logic        grant_nx;
   logic        pick;
   logic        abort;
   logic        s_valid_nx, s_instr_nx;
   logic [31:0] s_addr_nx, s_wdata_nx;
   logic [3:0]  s_wstrb_nx;
   logic        m0_ready_nx, m1_ready_nx;
   logic [31:0] m0_rdata_nx, m1_rdata_nx;
   logic [31:0] done_rdata;

`ifdef PICO_MEM_ARB_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] tmo_cnt;

   // s_ready on the terminal count wins over the abort
   assign abort = (state == BUSY) && !s_ready && (tmo_cnt == TMO_LAST);

   // Held at zero while IDLE so it is already clear on entry to BUSY
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == IDLE)
            tmo_cnt <= '0;
         else if (state == BUSY && !s_ready)
            tmo_cnt <= tmo_cnt + 16'd1;
         if (abort)
            timeout_err <= 1'b1;
      end
   end
`else
   assign abort       = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign busy = (state != IDLE);

   // Winner selection; last_grant resets to 1 so m0 takes the first contention
   always_comb begin
      pick = 1'b0;
      if (m0_valid && m1_valid)
         pick = (RR_EN != 0) ? !last_grant : 1'b0;
      else if (m1_valid)
         pick = 1'b1;
   end

   assign done_rdata = s_ready ? s_rdata : ERR_RDATA;

   always_comb begin
      state_nx      = state;
      last_grant_nx = last_grant;
      grant_nx      = grant;
      s_valid_nx    = s_valid;
      s_instr_nx    = s_instr;
      s_addr_nx     = s_addr;
      s_wdata_nx    = s_wdata;
      s_wstrb_nx    = s_wstrb;
      m0_ready_nx   = 1'b0;
      m1_ready_nx   = 1'b0;
      m0_rdata_nx   = m0_rdata;
      m1_rdata_nx   = m1_rdata;

      case (state)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               grant_nx   = pick;
               s_valid_nx = 1'b1;
               s_instr_nx = pick ? m1_instr : m0_instr;
               s_addr_nx  = pick ? m1_addr  : m0_addr;
               s_wdata_nx = pick ? m1_wdata : m0_wdata;
               s_wstrb_nx = pick ? m1_wstrb : m0_wstrb;
               state_nx   = BUSY;
            end
         end
         BUSY: begin
            if (s_ready || abort) begin
               s_valid_nx    = 1'b0;
               last_grant_nx = grant;
               state_nx      = DONE;
               if (grant) begin
                  m1_ready_nx = 1'b1;
                  m1_rdata_nx = done_rdata;
               end else begin
                  m0_ready_nx = 1'b1;
                  m0_rdata_nx = done_rdata;
               end
            end
         end
         // Ready pulse cycle; no arbitration so the served valid is not re-sampled
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         s_valid    <= 1'b0;
         s_instr    <= 1'b0;
         s_addr     <= '0;
         s_wdata    <= '0;
         s_wstrb    <= '0;
         m0_ready   <= 1'b0;
         m1_ready   <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         state      <= state_nx;
         last_grant <= last_grant_nx;
         grant      <= grant_nx;
         s_valid    <= s_valid_nx;
         s_instr    <= s_instr_nx;
         s_addr     <= s_addr_nx;
         s_wdata    <= s_wdata_nx;
         s_wstrb    <= s_wstrb_nx;
         m0_ready   <= m0_ready_nx;
         m1_ready   <= m1_ready_nx;
         m0_rdata   <= m0_rdata_nx;
         m1_rdata   <= m1_rdata_nx;
      end
   end

endmodule

// File: tb/tb_pico_mem_arbiter.sv
// Directed bench for pico_mem_arbiter. A round-robin instance (dut) is fully
// checked; a fixed-priority instance (dut_fp) shares all inputs and is checked
// for its grant during contention. Build with PICO_MEM_ARB_TIMEOUT_EN defined
// to also exercise the watchdog (TIMEOUT_CYCLES=8 on both instances).
module tb_pico_mem_arbiter;

   logic        HCLK, HRESET;
   logic        m0_valid, m0_instr, m1_valid, m1_instr;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        s_ready;
   logic [31:0] s_rdata;

   logic        m0_ready, m1_ready, s_valid, s_instr, grant, busy, timeout_err;
   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
   logic [3:0]  s_wstrb;

   logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_s_instr, fp_grant, fp_busy, fp_timeout_err;
   logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
   logic [3:0]  fp_s_wstrb;

   typedef struct {
      logic        port;
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl_rd [2];
   int unsigned n_pass, n_total;

   pico_mem_arbiter #(.RR_EN(1), .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(grant), .busy(busy), .timeout_err(timeout_err)
   );

   pico_mem_arbiter #(.RR_EN(0), .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)) dut_fp (
      .HCLK(HCLK), .HRESET(HRESET),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
      .s_valid(fp_s_valid), .s_instr(fp_s_instr), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
      .s_wstrb(fp_s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(fp_grant), .busy(fp_busy), .timeout_err(fp_timeout_err)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic set_m0(input logic v, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
      m0_valid = v; m0_instr = ins; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
   endtask

   task automatic set_m1(input logic v, input logic ins, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
      m1_valid = v; m1_instr = ins; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
   endtask

   task automatic push(input logic p, input logic ins, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd);
      exp_t e;
      e.port = p; e.instr = ins; e.addr = a; e.wdata = wd; e.wstrb = ws; e.rdata = rd;
      sb.push_back(e);
   endtask

   task automatic chk_req(input exp_t e);
      chk("s_instr", {31'd0, s_instr}, {31'd0, e.instr});
      chk("s_addr", s_addr, e.addr);
      chk("s_wdata", s_wdata, e.wdata);
      chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, e.wstrb});
   endtask

   // Waits for the head-of-queue request downstream, holds it d BUSY cycles,
   // then completes it with s_ready (respond=1) or lets the watchdog fire.
   task automatic run_txn(input int unsigned d, input bit respond, input bit chk_fp);
      exp_t e;
      int unsigned n;
      n = 0;
      while (s_valid !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      chk("s_valid_latency", n, 32'd1);
      if (sb.size() == 0) begin
         chk("scoreboard_nonempty", 32'd0, 32'd1);
         return;
      end
      e = sb[0];
      chk("grant", {31'd0, grant}, {31'd0, e.port});
      chk("busy", {31'd0, busy}, 32'd1);
      chk_req(e);
      if (chk_fp) chk("fp_grant", {31'd0, fp_grant}, 32'd0);
      for (int unsigned i = 0; i < d; i++) begin
         step();
         chk("s_valid_hold", {31'd0, s_valid}, 32'd1);
         chk_req(e);
         chk("no_early_ready", {31'd0, m0_ready | m1_ready}, 32'd0);
      end
      if (respond) begin
         s_ready = 1'b1;
         s_rdata = e.rdata;
      end
      step();
      s_ready = 1'b0;
      s_rdata = 32'h0BAD_0BAD;
      e = sb.pop_front();
      mdl_rd[e.port] = e.rdata;
      chk("m0_ready", {31'd0, m0_ready}, {31'd0, e.port == 1'b0});
      chk("m1_ready", {31'd0, m1_ready}, {31'd0, e.port == 1'b1});
      chk("m0_rdata", m0_rdata, mdl_rd[0]);
      chk("m1_rdata", m1_rdata, mdl_rd[1]);
      chk("s_valid_drop", {31'd0, s_valid}, 32'd0);
      step();
      chk("ready_one_cycle", {31'd0, m0_ready | m1_ready}, 32'd0);
      chk("idle_after_done", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      mdl_rd[0] = '0;
      mdl_rd[1] = '0;
      HRESET = 1'b1;
      s_ready = 1'b0;
      s_rdata = '0;
      set_m0(1'b0, 1'b0, '0, '0, '0);
      set_m1(1'b0, 1'b0, '0, '0, '0);
      step();
      chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_grant", {31'd0, grant}, 32'd0);
      chk("rst_s_addr", s_addr, 32'd0);
      chk("rst_m0_rdata", m0_rdata, 32'd0);
      chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      HRESET = 1'b0;
      step();

      // m1 write, held across a 5-cycle downstream wait
      set_m1(1'b1, 1'b0, 32'h5000_0000, 32'hA5A5_5A5A, 4'b0011);
      push(1'b1, 1'b0, 32'h5000_0000, 32'hA5A5_5A5A, 4'b0011, 32'h0000_0000);
      run_txn(5, 1'b1, 1'b0);
      set_m1(1'b0, 1'b0, '0, '0, '0);

      // Contention: round-robin 0,1,0,1; fixed priority stays on m0
      set_m0(1'b1, 1'b1, 32'h0000_1000, 32'h0, 4'b0000);
      set_m1(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'b0000);
      push(1'b0, 1'b1, 32'h0000_1000, 32'h0, 4'b0000, 32'h1111_0001);
      push(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'b0000, 32'h2222_0002);
      push(1'b0, 1'b1, 32'h0000_1000, 32'h0, 4'b0000, 32'h3333_0003);
      push(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'b0000, 32'h4444_0004);
      for (int k = 0; k < 4; k++) run_txn(2, 1'b1, 1'b1);
      set_m0(1'b0, 1'b0, '0, '0, '0);
      set_m1(1'b0, 1'b0, '0, '0, '0);

      // Single m0 read, s_ready 3 cycles after s_valid
      set_m0(1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'b0000);
      push(1'b0, 1'b0, 32'h4000_0000, 32'h0, 4'b0000, 32'h0000_0013);
      chk("s_valid_before_sample", {31'd0, s_valid}, 32'd0);
      run_txn(3, 1'b1, 1'b0);
      set_m0(1'b0, 1'b0, '0, '0, '0);

      // Stray s_ready while idle must be ignored
      s_ready = 1'b1;
      s_rdata = 32'hFFFF_FFFF;
      step();
      s_ready = 1'b0;
      chk("idle_sready_busy", {31'd0, busy}, 32'd0);
      chk("idle_sready_rdy", {31'd0, m0_ready | m1_ready}, 32'd0);
      chk("idle_sready_rdata", m0_rdata, mdl_rd[0]);
      chk("no_timeout_err", {31'd0, timeout_err}, 32'd0);

`ifdef PICO_MEM_ARB_TIMEOUT_EN
      // s_ready on the 8th BUSY cycle beats the terminal count
      set_m0(1'b1, 1'b0, 32'h4000_0010, 32'h0, 4'b0000);
      push(1'b0, 1'b0, 32'h4000_0010, 32'h0, 4'b0000, 32'h1234_5678);
      run_txn(7, 1'b1, 1'b0);
      chk("tmo_race_err", {31'd0, timeout_err}, 32'd0);
      set_m0(1'b0, 1'b0, '0, '0, '0);

      // No response: abort after 8 BUSY cycles with the error pattern
      set_m0(1'b1, 1'b0, 32'h4000_0020, 32'h0, 4'b0000);
      push(1'b0, 1'b0, 32'h4000_0020, 32'h0, 4'b0000, 32'hDEAD_BEEF);
      run_txn(7, 1'b0, 1'b0);
      chk("tmo_err_set", {31'd0, timeout_err}, 32'd1);
      set_m0(1'b0, 1'b0, '0, '0, '0);

      set_m0(1'b1, 1'b0, 32'h4000_0030, 32'h0, 4'b0000);
      push(1'b0, 1'b0, 32'h4000_0030, 32'h0, 4'b0000, 32'h0000_00AA);
      run_txn(1, 1'b1, 1'b0);
      chk("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);
      set_m0(1'b0, 1'b0, '0, '0, '0);
`endif

      // Reset while BUSY; last served was m0, so only reset makes m0 win next
      set_m0(1'b1, 1'b0, 32'h4000_0040, 32'h0, 4'b0000);
      step();
      chk("pre_rst_s_valid", {31'd0, s_valid}, 32'd1);
      step();
      HRESET = 1'b1;
      #1;
      chk("midrst_s_valid", {31'd0, s_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_m0_ready", {31'd0, m0_ready}, 32'd0);
      chk("midrst_m1_ready", {31'd0, m1_ready}, 32'd0);
      chk("midrst_timeout_err", {31'd0, timeout_err}, 32'd0);
      sb.delete();
      mdl_rd[0] = '0;
      mdl_rd[1] = '0;
      set_m0(1'b0, 1'b0, '0, '0, '0);
      step();
      step();
      chk("inrst_ready", {31'd0, m0_ready | m1_ready}, 32'd0);
      HRESET = 1'b0;
      step();

      set_m0(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'b0000);
      set_m1(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'b0000);
      push(1'b0, 1'b0, 32'h0000_3000, 32'h0, 4'b0000, 32'h5555_0005);
      push(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'b0000, 32'h6666_0006);
      run_txn(1, 1'b1, 1'b0);
      run_txn(1, 1'b1, 1'b0);
      set_m0(1'b0, 1'b0, '0, '0, '0);
      set_m1(1'b0, 1'b0, '0, '0, '0);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
